rv32i_csr_unit: RTL
===================

# rv32i_csr_unit

Control/status register unit of the SMU RV32I core, in the execute stage beside the ALU. It executes the six Zicsr instructions and holds the 64-bit cycle and instret counters. It also holds the `tohost` register (CSR 0x51E), whose value the system exports as `csr`, the word ISA-test benches poll for pass/fail. `tohost` is sticky once bit 0 is set, so a finished test result cannot be overwritten by stray later writes.

## Interface
- `HART_ID`, default 0: value returned by `mhartid` (0xF14).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `csr_en` in 1: a CSR instruction is present in execute this cycle.
- `stall` in 1: execute stalled; suppresses all CSR writes and `illegal`.
- `csr_funct3` in 3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csr_addr` in 12: CSR address.
- `rs1_idx` in 5: rs1 field; also zimm for immediate forms.
- `rs1_data` in 32: rs1 operand after forwarding.
- `retire` in 1: one instruction retires this cycle.
- `csr_rdata` out 32: old value of the addressed CSR, combinational, for rd writeback.
- `illegal` out 1: combinational; unsupported address, or write to a read-only CSR.
- `tohost` out 32: registered `tohost` value; drives the system `csr` output.
- `tohost_wr` out 1: one-cycle pulse, high in the cycle `tohost` shows a newly written value.

## Operation
- Supported CSRs:
  - 0x51E `tohost`, read/write.
  - 0xC00 `cycle`, 0xC80 `cycleh`, 0xC02 `instret`, 0xC82 `instreth`, 0xF14 `mhartid`, all read-only.
- Any other address: `illegal`=1, `csr_rdata`=0, no state change.
- Source operand `src`: `rs1_data` for funct3[2]=0; zero-extended `rs1_idx` for funct3[2]=1.
- New value: RW/RWI = `src`; RS/RSI = old | `src`; RC/RCI = old & ~`src`.
- Write intent:
  - RW/RWI: always.
  - RS/RC forms: only when `rs1_idx`≠0.
  - Read-only CSR with write intent: `illegal`=1, no change.
  - RS/RC with `rs1_idx`=0 on a read-only CSR is a legal read.
- Commit condition: `csr_en & ~stall & ~illegal & write_intent`.
- `illegal` is gated by `csr_en & ~stall`. funct3 000/100 with `csr_en`: `illegal`=1.
- Sticky `tohost`:
  - Internal `done` flag is set on the edge a committed write leaves `tohost[0]`=1.
  - While `done`=1, `tohost` writes are dropped silently (not illegal).
  - Reads still return the frozen value.
- Counters:
  - 64-bit `cycle_q` increments every cycle with `rst`=0.
  - 64-bit `instret_q` increments on each cycle with `retire`=1.
  - Both wrap from 2^64−1 to 0. The carry from the low word into the high word happens on the same edge.
  - `cycle`/`instret` read bits 31:0; the `h` variants read bits 63:32.
- Reset values: `tohost`=0, `done`=0, `tohost_wr`=0, `cycle_q`=0, `instret_q`=0.
- `csr_rdata` and `illegal` follow their inputs combinationally, including during reset.

## Timing
- Reads are zero-latency: `csr_rdata` holds the pre-edge value. A counter read sees the value before that cycle's increment.
- A committed write is visible on `tohost` one edge later. `tohost_wr`=1 for exactly that one cycle.
- Back-to-back writes on consecutive cycles: each is applied in order. Each pulses `tohost_wr`, unless dropped by `done`.
- `stall`=1 with `csr_en`=1: nothing changes. The instruction is presented again later.
- `retire` coincident with a counter read: the read returns the old value; the increment still occurs.
- `rst` asserted mid-operation: every register returns to its reset value on the next edge. A write in that cycle is discarded, and `done` clears.
- The first edge after `rst` falls gives `cycle_q`=1.

## Test plan
- Reset for 30 cycles, deassert at negedge, wait 10 posedges, then read 0xC00 (RS, `rs1_idx`=0) -> `csr_rdata`=10, `illegal`=0; read 0xC80 -> 0.
- RWI 0x51E, zimm=1 -> `csr_rdata`=0 during the op; next cycle `tohost`=0x1 and `tohost_wr`=1 for one cycle; a following RW of 0xABCD -> `tohost` stays 0x1, no pulse.
- With `tohost`=0x2, RS 0x51E `rs1_data`=0x4 -> `rdata`=0x2, then `tohost`=0x6; then RC `rs1_data`=0x2 -> `tohost`=0x4; then RW 0x7 (test 3 failed) -> `tohost`=0x7 and frozen.
- RW 0xC00 -> `illegal`=1, `cycle` keeps counting; RW 0x123 -> `illegal`=1, `rdata`=0; any CSR op with `stall`=1 -> no change, `illegal`=0.
- 5 `retire` pulses with 3 gaps -> `instret`=5, `instreth`=0; `rst` mid-sequence -> `instret`=0, `tohost`=0, `done` cleared so a new `tohost` write succeeds.
- Read 0xF14 with `HART_ID`=0 -> 0.

Source files
------------

// File: rtl/rv32i_csr_unit.sv
// rtl/rv32i_csr_unit.sv - Zicsr execute unit with cycle/instret counters and sticky tohost
module rv32i_csr_unit #(
    parameter logic [31:0] HART_ID = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic        stall,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] rs1_data,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic        illegal,
    output logic [31:0] tohost,
    output logic        tohost_wr
);

    localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    logic [63:0] cycle_q;
    logic [63:0] instret_q;
    logic        done_q;

    logic [31:0] old_val;
    logic        addr_ok;
    logic        read_only;
    logic        is_tohost;
    logic        funct3_ok;
    logic        write_intent;
    logic        active;
    logic [31:0] src;
    logic [31:0] new_val;
    logic        tohost_commit;

    // Address decode: old value of the addressed CSR plus its access class
    always_comb begin
        old_val   = 32'd0;
        addr_ok   = 1'b1;
        read_only = 1'b1;
        is_tohost = 1'b0;
        case (csr_addr)
            ADDR_TOHOST: begin
                old_val   = tohost;
                read_only = 1'b0;
                is_tohost = 1'b1;
            end
            ADDR_CYCLE:    old_val = cycle_q[31:0];
            ADDR_CYCLEH:   old_val = cycle_q[63:32];
            ADDR_INSTRET:  old_val = instret_q[31:0];
            ADDR_INSTRETH: old_val = instret_q[63:32];
            ADDR_MHARTID:  old_val = HART_ID;
            default: begin
                addr_ok   = 1'b0;
                read_only = 1'b0;
            end
        endcase
    end

    // Operand selection, read-modify-write value and legality of the instruction
    always_comb begin
        funct3_ok    = (csr_funct3[1:0] != 2'b00);
        // RW forms always write; set/clear forms only with a non-zero rs1/zimm field
        write_intent = (csr_funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
        active       = csr_en && !stall;
        src          = csr_funct3[2] ? {27'd0, rs1_idx} : rs1_data;
        case (csr_funct3[1:0])
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = src;
        endcase
        illegal       = active && (!funct3_ok || !addr_ok || (read_only && write_intent));
        csr_rdata     = old_val;
        // Once done is set, tohost writes are swallowed without raising illegal
        tohost_commit = active && !illegal && write_intent && is_tohost && !done_q;
    end

    // Counters, tohost register, its update pulse and the sticky done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
            tohost    <= 32'd0;
            tohost_wr <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
            tohost_wr <= tohost_commit;
            if (tohost_commit) begin
                tohost <= new_val;
                if (new_val[0]) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule
